// File: rtl/demosaic_bilinear_stream.sv
// Bilinear Bayer demosaic: buffers one raw frame, then streams full-frame RGB
// in raster order with mirror-extended borders and output backpressure.
module demosaic_bilinear_stream #(
    parameter int PIX_W  = 12,
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfa,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*PIX_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int SW    = PIX_W + 2;
    localparam int DEPTH = IMG_W * IMG_H;

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t state_q, state_d;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [1:0]       cfa_q;
    logic             last_xy, in_fire, out_load;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [YW-1:0] yy, input logic [XW-1:0] xx);
        return ADDR_W'(yy) * ADDR_W'(IMG_W) + ADDR_W'(xx);
    endfunction

    function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(1);
        return PIX_W'(s >> 1);
    endfunction

    function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] d);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(c) + SW'(d) + SW'(2);
        return PIX_W'(s >> 2);
    endfunction

    assign last_xy  = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
    assign in_fire  = (state_q == LOAD) && in_valid;
    assign out_load = (state_q == OUT) && (!out_valid || out_ready);

    // Mirror extension reflects about the edge pixel, keeping CFA parity.
    logic [XW-1:0] xm, xp;
    logic [YW-1:0] ym, yp;
    assign xm = (x == '0) ? XW'(1) : x - XW'(1);
    assign xp = (x == XW'(IMG_W - 1)) ? XW'(IMG_W - 2) : x + XW'(1);
    assign ym = (y == '0) ? YW'(1) : y - YW'(1);
    assign yp = (y == YW'(IMG_H - 1)) ? YW'(IMG_H - 2) : y + YW'(1);

    logic [PIX_W-1:0] pc, pn, ps, pw, pe, pnw, pne, psw, pse;
    assign pc  = mem[addr_of(y,  x)];
    assign pn  = mem[addr_of(ym, x)];
    assign ps  = mem[addr_of(yp, x)];
    assign pw  = mem[addr_of(y,  xm)];
    assign pe  = mem[addr_of(y,  xp)];
    assign pnw = mem[addr_of(ym, xm)];
    assign pne = mem[addr_of(ym, xp)];
    assign psw = mem[addr_of(yp, xm)];
    assign pse = mem[addr_of(yp, xp)];

    logic r_row, r_col;
    logic [PIX_W-1:0] r_v, g_v, b_v;
    assign r_row = (y[0] == cfa_q[1]);
    assign r_col = (x[0] == cfa_q[0]);

    always_comb begin
        r_v = pc;
        g_v = pc;
        b_v = pc;
        if (r_row && r_col) begin
            g_v = avg4(pn, ps, pw, pe);
            b_v = avg4(pnw, pne, psw, pse);
        end else if (!r_row && !r_col) begin
            g_v = avg4(pn, ps, pw, pe);
            r_v = avg4(pnw, pne, psw, pse);
        end else if (r_row) begin
            r_v = avg2(pw, pe);
            b_v = avg2(pn, ps);
        end else begin
            r_v = avg2(pn, ps);
            b_v = avg2(pw, pe);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_xy) state_d = OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame buffer carries no reset; only LOAD handshakes write it.
    always_ff @(posedge clk) begin
        if (in_fire) mem[addr_of(y, x)] <= in_data;
    end

    // x/y serve as the write pointer in LOAD and the next-pixel pointer in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            cfa_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE && start) begin
                cfa_q <= cfa;
                x     <= '0;
                y     <= '0;
            end
            if (in_fire || (out_load && !(out_valid && out_last))) begin
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            if (out_load) begin
                if (out_valid && out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= {r_v, g_v, b_v};
                    out_last  <= last_xy;
                end
            end
        end
    end
endmodule
